// File: rtl/snn_pkg.sv
// snn_pkg: shared types and saturating arithmetic helpers for the SNN datapath.
// Revision: 1.0
`default_nettype none

package snn_pkg;

    localparam int DEF_W_WIDTH = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } acc_state_t;

    // Unsigned add clamped to 2^width-1; width must be below 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          width);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

    function automatic logic [31:0] sat_trunc(input logic [31:0] sum,
                                              input int          to_width);
        logic [32:0] lim;
        lim = (33'd1 << to_width) - 33'd1;
        return ({1'b0, sum} > lim) ? lim[31:0] : sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/synapse_weight_mem.sv
// synapse_weight_mem: flop-based weight file, one sync write port, one async read port.
// Revision: 1.0
`default_nettype none

module synapse_weight_mem #(
    parameter int N_SYN   = 16,
    parameter int W_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(N_SYN)-1:0]   wr_addr,
    input  logic [W_WIDTH-1:0]         wr_data,
    input  logic [$clog2(N_SYN)-1:0]   rd_addr,
    output logic [W_WIDTH-1:0]         rd_data
);

    logic [W_WIDTH-1:0] mem [N_SYN];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_SYN; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read sees the pre-write contents when a write hits the same index.
    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/synapse_accumulator.sv
// synapse_accumulator: per-timestep saturating sum of weighted spike events for the soma.
// Revision: 1.0
`default_nettype none

module synapse_accumulator
    import snn_pkg::*;
#(
    parameter int N_SYN     = 16,
    parameter int W_WIDTH   = DEF_W_WIDTH,
    parameter int SUM_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_en,
    input  logic [$clog2(N_SYN)-1:0]   prog_addr,
    input  logic [W_WIDTH-1:0]         prog_data,
    input  logic                       ev_valid,
    input  logic [$clog2(N_SYN)-1:0]   ev_addr,
    output logic                       ev_ready,
    input  logic                       tick,
    input  logic                       suspend,
    output logic                       out_valid,
    output logic [W_WIDTH-1:0]         out_weight,
    output logic                       out_spike,
    output logic                       overrun
);

    acc_state_t           state;
    acc_state_t           next_state;
    logic [SUM_WIDTH-1:0] sum;
    logic [SUM_WIDTH-1:0] sum_nxt;
    logic                 hit;
    logic                 hit_nxt;
    logic [W_WIDTH-1:0]   ev_weight;
    logic [W_WIDTH-1:0]   closing_weight;
    logic                 accept;
    logic                 closing;

    synapse_weight_mem #(
        .N_SYN   (N_SYN),
        .W_WIDTH (W_WIDTH)
    ) u_weight_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (prog_en),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (ev_addr),
        .rd_data (ev_weight)
    );

    assign accept  = ev_valid & ev_ready;
    assign closing = (state == ACCUM) & tick;

    always_comb begin
        next_state = state;
        sum_nxt    = sum;
        hit_nxt    = hit;
        case (state)
            ACCUM: begin
                // Suspended events are still consumed, just not counted.
                if (accept && !suspend) begin
                    sum_nxt = SUM_WIDTH'(sat_add(32'(sum), 32'(ev_weight), SUM_WIDTH));
                    hit_nxt = 1'b1;
                end
                if (tick) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                next_state = ACCUM;
                sum_nxt    = '0;
                hit_nxt    = 1'b0;
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
    end

    assign closing_weight = W_WIDTH'(sat_trunc(32'(sum_nxt), W_WIDTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ACCUM;
            sum        <= '0;
            hit        <= 1'b0;
            ev_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_weight <= '0;
            out_spike  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state     <= next_state;
            sum       <= sum_nxt;
            hit       <= hit_nxt;
            ev_ready  <= (next_state == ACCUM);
            out_valid <= closing;
            // Output word is captured on the closing edge so it is visible during FLUSH.
            if (closing) begin
                out_weight <= closing_weight;
                out_spike  <= hit_nxt;
            end
            if ((state == FLUSH) && tick) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_synapse_accumulator.sv
// tb_synapse_accumulator: directed scoreboard bench for synapse_accumulator.
// Revision: 1.0
`default_nettype none

module tb_synapse_accumulator;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog_en;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       ev_valid;
    logic [3:0] ev_addr;
    logic       ev_ready;
    logic       tick;
    logic       suspend;
    logic       out_valid;
    logic [7:0] out_weight;
    logic       out_spike;
    logic       overrun;

    always #5 clk = ~clk;

    synapse_accumulator #(
        .N_SYN     (N),
        .W_WIDTH   (8),
        .SUM_WIDTH (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_en    (prog_en),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .ev_valid   (ev_valid),
        .ev_addr    (ev_addr),
        .ev_ready   (ev_ready),
        .tick       (tick),
        .suspend    (suspend),
        .out_valid  (out_valid),
        .out_weight (out_weight),
        .out_spike  (out_spike),
        .overrun    (overrun)
    );

    typedef struct {
        logic [7:0] w;
        logic       s;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int a, input int d);
        prog_en   = 1'b1;
        prog_addr = 4'(a);
        prog_data = 8'(d);
        step();
        prog_en   = 1'b0;
    endtask

    task automatic ev(input int a, input logic s);
        ev_valid = 1'b1;
        ev_addr  = 4'(a);
        suspend  = s;
        step();
        ev_valid = 1'b0;
        suspend  = 1'b0;
    endtask

    // Closes the timestep; the FLUSH cycle must deassert ev_ready.
    task automatic do_tick(input int w, input logic s);
        tick = 1'b1;
        sb.push_back('{w: 8'(w), s: s, cyc: cyc + 1});
        step();
        tick = 1'b0;
        chk("ev_ready_in_flush", 32'(ev_ready), 0);
        step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_weight", 32'(out_weight), 32'(e.w));
                chk("out_spike", 32'(out_spike), 32'(e.s));
                chk("out_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; prog_en = 1'b0; prog_addr = '0; prog_data = '0;
        ev_valid = 1'b0; ev_addr = '0; tick = 1'b0; suspend = 1'b0;

        repeat (3) step();
        chk("rst_ev_ready", 32'(ev_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_weight", 32'(out_weight), 0);
        chk("rst_out_spike", 32'(out_spike), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b1;
        step();
        chk("ev_ready_after_rst", 32'(ev_ready), 1);

        // Basic weighted sum
        prog(3, 10);
        prog(5, 20);
        ev(3, 1'b0); ev(5, 1'b0); ev(3, 1'b0);
        do_tick(40, 1'b1);

        // Event in the tick cycle belongs to the closing timestep
        ev_valid = 1'b1; ev_addr = 4'd3; tick = 1'b1;
        sb.push_back('{w: 8'd10, s: 1'b1, cyc: cyc + 1});
        step();
        ev_valid = 1'b0; tick = 1'b0;
        step();
        do_tick(0, 1'b0);

        // Output clamp: 16 x 200 = 3200
        for (int i = 0; i < N; i++) prog(i, 200);
        for (int i = 0; i < N; i++) ev(i, 1'b0);
        do_tick(255, 1'b1);

        // Accumulator saturation: 21 x 200 = 4200 > 4095 (wrap would give 104)
        for (int i = 0; i < 21; i++) ev(i % N, 1'b0);
        do_tick(255, 1'b1);

        // Exactly full-scale
        prog(1, 55);
        prog(2, 100);
        ev(2, 1'b0); ev(2, 1'b0); ev(1, 1'b0);
        do_tick(255, 1'b1);

        // Empty timestep, then tick during FLUSH
        chk("overrun_before", 32'(overrun), 0);
        tick = 1'b1;
        sb.push_back('{w: 8'd0, s: 1'b0, cyc: cyc + 1});
        step();
        chk("ev_ready_in_flush_overrun", 32'(ev_ready), 0);
        step();
        tick = 1'b0;
        chk("overrun_set", 32'(overrun), 1);
        step();
        // Minimum tick spacing of two cycles
        do_tick(0, 1'b0);
        do_tick(0, 1'b0);
        chk("overrun_sticky", 32'(overrun), 1);

        // Suspend discards events but still consumes them
        prog(2, 9);
        prog(7, 9);
        ev_valid = 1'b1; ev_addr = 4'd2; suspend = 1'b1;
        chk("ev_ready_suspend_a", 32'(ev_ready), 1);
        step();
        ev_addr = 4'd7;
        chk("ev_ready_suspend_b", 32'(ev_ready), 1);
        step();
        ev_valid = 1'b0; suspend = 1'b0;
        ev(2, 1'b0);
        do_tick(9, 1'b1);
        ev(7, 1'b1);
        do_tick(0, 1'b0);

        // Read-before-write on the weight file
        prog(4, 7);
        prog_en = 1'b1; prog_addr = 4'd4; prog_data = 8'd50;
        ev_valid = 1'b1; ev_addr = 4'd4;
        step();
        prog_en = 1'b0; ev_valid = 1'b0;
        do_tick(7, 1'b1);
        ev(4, 1'b0);
        do_tick(50, 1'b1);

        // Reset mid-timestep
        prog(1, 10);
        prog(2, 20);
        ev(1, 1'b0); ev(2, 1'b0);
        rst = 1'b0;
        step();
        chk("ev_ready_mid_rst", 32'(ev_ready), 0);
        step();
        rst = 1'b1;
        step();
        chk("overrun_cleared", 32'(overrun), 0);
        chk("ev_ready_after_mid_rst", 32'(ev_ready), 1);
        do_tick(0, 1'b0);
        for (int i = 0; i < N; i++) ev(i, 1'b0);
        do_tick(0, 1'b1);

        repeat (5) step();
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
